// File: rtl/frame_buffer_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frame_buffer_writer_pkg
// Description : Shared video definitions. Holds the default active-video
//               geometry and pixel/address widths that are common to the image
//               BRAM, the VGA reader and the frame buffer writer. It also holds
//               the write-side FSM state encoding.
// Contents    : VID_H_ACTIVE, VID_V_ACTIVE, VID_DATA_W, VID_ADDR_W,
//               fbw_state_t {IDLE, WAIT_SOF, WRITE}
// Revision    : 1.0 - initial release
// ============================================================================
package frame_buffer_writer_pkg;

  // Default 320x240 RGB444 frame store
  localparam int VID_H_ACTIVE = 320;
  localparam int VID_V_ACTIVE = 240;
  localparam int VID_DATA_W   = 12;
  localparam int VID_ADDR_W   = 17;   // 2^17 >= 320*240

  // Write-side FSM encoding
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    WRITE    = 2'd2
  } fbw_state_t;

endpackage : frame_buffer_writer_pkg
`default_nettype wire

// File: rtl/frame_buffer_writer_raster_counter.sv
`default_nettype none
// ============================================================================
// Module      : frame_buffer_writer_raster_counter
// Description : Raster position tracker for the frame buffer writer. Keeps the
//               column (x), line (y) and linear BRAM address of the NEXT pixel
//               expected in the stream, and classifies the current beat's
//               end-of-line marker against the column position.
//               The address runs alongside x/y as a plain incrementer, so no
//               y*H_ACTIVE product is ever formed.
// Ports       : clk, rst_n      clock / async active-low reset
//               restart         current beat is pixel (0,0): next is (1,0), addr 1
//               step            current beat accepted at the running position
//               clear           return to (0,0), addr 0 (frame end or abort)
//               eol             end-of-line marker of the current beat
//               addr            running address of the current beat
//               line_err        eol disagrees with the column position
//               frame_end       current beat is a correct last pixel of frame
// Revision    : 1.0 - initial release
// ============================================================================
module frame_buffer_writer_raster_counter #(
  parameter int H_ACTIVE = 320,
  parameter int V_ACTIVE = 240,
  parameter int ADDR_W   = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              restart,
  input  logic              step,
  input  logic              clear,
  input  logic              eol,
  output logic [ADDR_W-1:0] addr,
  output logic              line_err,
  output logic              frame_end
);

  localparam int X_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int Y_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  localparam logic [X_W-1:0] X_LAST = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_ACTIVE - 1);

  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic           at_last_col;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (clear) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (restart) begin
      // The restarting beat itself occupies (0,0) / address 0.
      x    <= X_W'(1);
      y    <= '0;
      addr <= ADDR_W'(1);
    end else if (step) begin
      // The caller only steps on beats that passed the line check and are not
      // the final pixel, so reaching the last column implies a clean line end
      // and y never advances past V_ACTIVE-1.
      if (at_last_col) begin
        x <= '0;
        y <= y + Y_W'(1);
      end else begin
        x <= x + X_W'(1);
      end
      addr <= addr + ADDR_W'(1);
    end
  end

  assign at_last_col = (x == X_LAST);
  // Short line (eol early) and long line (no eol at last column) both land here.
  assign line_err    = (at_last_col != eol);
  assign frame_end   = at_last_col && eol && (y == Y_LAST);

endmodule : frame_buffer_writer_raster_counter
`default_nettype wire

// File: rtl/frame_buffer_writer.sv
`default_nettype none
// ============================================================================
// Module      : frame_buffer_writer
// Description : Write-side companion of the RGB444 image BRAM. Accepts a
//               raster-ordered valid/ready pixel stream with start-of-frame and
//               end-of-line markers, and drives registered BRAM write strobe,
//               address and data one cycle after each kept beat. Checks line
//               and frame geometry, pulses frame_done on a complete frame and
//               frame_err on a malformed one, then waits for the next SOF.
// Ports       : clk, rst_n          clock / async active-low reset
//               enable              capture enable, acted on at frame boundaries
//               s_valid/s_ready     stream handshake (ready decoded from state)
//               s_data/s_sof/s_eol  pixel and framing markers
//               wr_en/wr_addr/wr_data  BRAM write port (registered)
//               busy                high while a frame is being written
//               frame_done          one-cycle pulse, frame fully written
//               frame_err           one-cycle pulse, frame aborted/restarted
// Revision    : 1.0 - initial release
// ============================================================================
module frame_buffer_writer
  import frame_buffer_writer_pkg::*;
#(
  parameter int H_ACTIVE = VID_H_ACTIVE,
  parameter int V_ACTIVE = VID_V_ACTIVE,
  parameter int DATA_W   = VID_DATA_W,
  parameter int ADDR_W   = VID_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_sof,
  input  logic              s_eol,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err
);

  fbw_state_t state, state_next;

  logic              accept;
  logic              wr_next;
  logic              done_next;
  logic              err_next;
  logic              cnt_restart;
  logic              cnt_step;
  logic              cnt_clear;
  logic [ADDR_W-1:0] cnt_addr;
  logic              cnt_line_err;
  logic              cnt_frame_end;

  // Ready depends on state only, so upstream never sees a valid->ready path.
  assign s_ready = (state != IDLE);
  assign busy    = (state == WRITE);
  assign accept  = s_valid && s_ready;

  frame_buffer_writer_raster_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .ADDR_W   (ADDR_W)
  ) u_raster (
    .clk       (clk),
    .rst_n     (rst_n),
    .restart   (cnt_restart),
    .step      (cnt_step),
    .clear     (cnt_clear),
    .eol       (s_eol),
    .addr      (cnt_addr),
    .line_err  (cnt_line_err),
    .frame_end (cnt_frame_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    wr_next     = 1'b0;
    done_next   = 1'b0;
    err_next    = 1'b0;
    cnt_restart = 1'b0;
    cnt_step    = 1'b0;
    cnt_clear   = 1'b0;

    unique case (state)
      IDLE: begin
        if (enable) begin
          state_next = WAIT_SOF;
        end
      end

      WAIT_SOF: begin
        // Disable wins here: a beat arriving with enable low is dropped like
        // any other beat outside a frame.
        if (!enable) begin
          state_next = IDLE;
        end else if (accept && s_sof) begin
          wr_next     = 1'b1;
          cnt_restart = 1'b1;
          state_next  = WRITE;
        end
      end

      WRITE: begin
        if (accept) begin
          // Every accepted beat in WRITE is written, even an offending one.
          wr_next = 1'b1;
          if (s_sof) begin
            // Premature restart: report it, then adopt this beat as (0,0).
            err_next    = 1'b1;
            cnt_restart = 1'b1;
          end else if (cnt_line_err) begin
            err_next   = 1'b1;
            cnt_clear  = 1'b1;
            state_next = WAIT_SOF;
          end else if (cnt_frame_end) begin
            done_next  = 1'b1;
            cnt_clear  = 1'b1;
            state_next = enable ? WAIT_SOF : IDLE;
          end else begin
            cnt_step = 1'b1;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // BRAM write port and status pulses, one cycle behind the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      wr_en      <= wr_next;
      frame_done <= done_next;
      frame_err  <= err_next;
      if (wr_next) begin
        // A restarting beat always lands at address 0 regardless of where
        // the running counter had got to.
        wr_addr <= cnt_restart ? '0 : cnt_addr;
        wr_data <= s_data;
      end
    end
  end

endmodule : frame_buffer_writer
`default_nettype wire

// File: doc/frame_buffer_writer.md
Name: frame_buffer_writer

Overview:
- Write-side companion to the 320x240 RGB444 image BRAM, which is read by address.
- Accepts a raster-ordered pixel stream using valid/ready plus start-of-frame and end-of-line markers.
- Generates registered write strobes, addresses and data into the BRAM write port.
- Checks frame geometry, reports completed and malformed frames, and resynchronises on the next start-of-frame.

Parameters:
- H_ACTIVE, 320, pixels per line
- V_ACTIVE, 240, lines per frame
- DATA_W, 12, pixel width (RGB444)
- ADDR_W, 17, BRAM address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  capture enable; sampled at frame boundaries
- s_valid  in  1  input pixel valid
- s_ready  out  1  input ready; a beat transfers when s_valid && s_ready
- s_data  in  DATA_W  input pixel
- s_sof  in  1  beat is pixel (0,0) of a frame
- s_eol  in  1  beat is the last pixel of a line
- wr_en  out  1  BRAM write strobe
- wr_addr  out  ADDR_W  BRAM write address, y*H_ACTIVE+x
- wr_data  out  DATA_W  BRAM write data
- busy  out  1  high in WRITE state
- frame_done  out  1  one-cycle pulse: full frame written
- frame_err  out  1  one-cycle pulse: malformed frame aborted

Behaviour:
- Reset values: state IDLE; wr_en=0, wr_addr=0, wr_data=0, frame_done=0, frame_err=0; x, y and address counters 0. s_ready and busy are decoded from state, so both are 0 in reset.
- Reset asserted mid-frame discards the frame. No done or error pulse is produced.
- s_ready = (state != IDLE). s_ready is a combinational decode of state only, never of s_valid.
- States and transitions:
  - IDLE: go to WAIT_SOF when enable=1.
  - WAIT_SOF: accepted beats with s_sof=0 are dropped (no write). An accepted beat with s_sof=1 is written at address 0, with x=1, y=0, and the block goes to WRITE. If enable=0 while in WAIT_SOF, go to IDLE.
  - WRITE: each accepted beat is written at the running address. Address increments by 1 per beat. No multiplier is used.
- Latency: a beat accepted in cycle N produces wr_en=1 with its wr_addr and wr_data in cycle N+1. wr_en=0 in every cycle with no accepted-and-kept beat. wr_addr and wr_data hold their last values when wr_en=0.
- Line check, for each accepted beat in WRITE at column x:
  - x==H_ACTIVE-1 and s_eol=1: line ok; x<=0, y<=y+1.
  - s_eol=1 with x<H_ACTIVE-1 (short line), or s_eol=0 with x==H_ACTIVE-1 (long line): the beat is still written, frame_err pulses in N+1, state goes to WAIT_SOF.
- Frame end: the beat at x=H_ACTIVE-1, y=V_ACTIVE-1 with s_eol=1 is written, and frame_done pulses in N+1 (coincident with the last wr_en). Next state is WAIT_SOF if enable=1, else IDLE.
- s_sof=1 in WRITE (premature restart): frame_err pulses in N+1. The same beat is treated as pixel (0,0): written at address 0, x=1, y=0, state stays WRITE.
- enable=0 in WRITE has no effect until the frame ends or aborts. Frames are never truncated by enable.
- frame_done and frame_err are never high in the same cycle. An error on the final beat reports err only.
- Counters: x needs ceil(log2(H_ACTIVE)) bits, y needs ceil(log2(V_ACTIVE)) bits, address is ADDR_W bits. All compare exactly against the parameters, with no wrap beyond H_ACTIVE*V_ACTIVE-1.

Decomposition:
- Shared video package holds:
  - H_ACTIVE/V_ACTIVE/DATA_W/ADDR_W defaults (320, 240, 12, 17), also used by the image BRAM and the VGA reader.
  - The state encoding constants IDLE/WAIT_SOF/WRITE.
- One natural sub-module: raster_counter (x/y/address counters with ok and line-error outputs). The FSM and write-port registers stay in frame_buffer_writer.

Test Plan:
- Reset then enable=1, full 320x240 frame with s_valid always 1 -> 76800 writes at addresses 0..76799 in order, wr_data matching input, one frame_done coincident with the write to 76799, no frame_err.
- Same frame with s_valid toggling pseudo-randomly -> identical write sequence, each wr_en exactly one cycle after its handshake.
- Three beats without s_sof, then a valid frame -> the first three beats produce no wr_en; the first write is at address 0.
- Line 5 ends with s_eol at x=100 -> write at address 5*320+100=1700, frame_err pulse, following beats dropped until s_sof, next frame written from 0.
- s_sof at address 50000 mid-frame -> frame_err pulse, that beat written at address 0, counting continues 1,2,...
- enable dropped at pixel 1000 -> frame completes with frame_done, then state IDLE and s_ready=0. Assert rst_n=0 mid-frame -> all outputs 0 immediately, no pulses.
